// File: rtl/fp_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_multiplier_seq
//  Description : Sequential single-precision multiplier (1/8/23, bias 127).
//                Radix-2 shift-add mantissa product over 24 enabled steps.
//                Results are truncated, with no denormals. An exponent field
//                of zero means zero. The CPU holds run, x and y high/stable
//                while stall is asserted.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_multiplier_seq (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active-low
    input  logic        ce,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    // Step counter value at which the product is complete and held.
    localparam logic [4:0]  c_S_DONE = 5'd25;
    localparam logic [9:0]  c_BIAS   = 10'd127;

    logic [4:0]  s_q, s_d;
    logic [47:0] p_q, p_d;

    logic [23:0] w_mx;
    logic [24:0] w_sum;
    logic [7:0]  w_xe, w_ye;
    logic [9:0]  w_e;
    logic [22:0] w_f;
    logic        w_s;

    // Multiplicand with hidden bit, and one shift-add step on the partial product.
    always_comb begin
        w_mx  = {1'b1, x[22:0]};
        w_sum = {1'b0, p_q[47:24]} + (p_q[0] ? {1'b0, w_mx} : 25'd0);
    end

    // Next-state: counter advances while run is high; P loads at S=0, steps at S=1..24.
    always_comb begin
        s_d = s_q;
        p_d = p_q;
        if (ce) begin
            if (!run) begin
                s_d = 5'd0;
            end else if (s_q != c_S_DONE) begin
                s_d = s_q + 5'd1;
                if (s_q == 5'd0) begin
                    p_d = {24'b0, 1'b1, y[22:0]};
                end else begin
                    p_d = {w_sum, p_q[23:1]};
                end
            end
        end
    end

    // State registers; reset clears counter and product immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= 5'd0;
            p_q <= 48'd0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
        end
    end

    // Stall mirrors run until the counter reaches its terminal value.
    always_comb begin
        stall = run & (s_q != c_S_DONE);
    end

    // Result assembly: normalise by P[47], signed 10-bit exponent, zero/underflow/overflow.
    always_comb begin
        w_xe = x[30:23];
        w_ye = y[30:23];
        w_s  = x[31] ^ y[31];
        w_e  = {2'b00, w_xe} + {2'b00, w_ye} - c_BIAS + {9'd0, p_q[47]};
        w_f  = p_q[47] ? p_q[46:24] : p_q[45:23];
        if ((w_xe == 8'd0) || (w_ye == 8'd0)) begin
            z = 32'd0;
        end else if (w_e[9] || (w_e == 10'd0)) begin
            z = 32'd0;
        end else if (w_e[8] || (w_e[7:0] == 8'hFF)) begin
            z = {w_s, 8'hFF, 23'd0};
        end else begin
            z = {w_s, w_e[7:0], w_f};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_multiplier_seq
//  Description : Directed, table-driven bench for fp_multiplier_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int checks = 0;
    int errors = 0;

    fp_multiplier_seq dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_z;
        string       name;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Waits (from a negedge+1 point) until stall drops, counting enabled and total clocks.
    task automatic wait_done(input bit toggle, output int en_cyc, output int clk_cyc);
        en_cyc  = 0;
        clk_cyc = 0;
        while (stall && clk_cyc < 300) begin
            if (ce) en_cyc++;
            clk_cyc++;
            @(negedge clk);
            if (toggle) ce = ~ce;
            #1;
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL timeout stall still high after %0d clocks", clk_cyc);
        end
    endtask

    // Launches one operation at a negedge and waits for completion.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit toggle,
                         output int en_cyc, output int clk_cyc);
        @(negedge clk);
        x   = a;
        y   = b;
        run = 1'b1;
        ce  = toggle ? 1'b0 : 1'b1;
        #1;
        wait_done(toggle, en_cyc, clk_cyc);
    endtask

    // Drops run for one enabled clock so the counter returns to zero.
    task automatic end_op();
        run = 1'b0;
        ce  = 1'b1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int en_c;
        int clk_c;
        logic [31:0] z_hold;

        vecs[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, "one_x_one"};
        vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, "1p5_sq"};
        vecs[2] = '{32'h40000000, 32'hC0400000, 32'hC0C00000, "two_x_m3"};
        vecs[3] = '{32'h00000000, 32'h40490FDB, 32'h00000000, "zero_x"};
        vecs[4] = '{32'h00800000, 32'h00800000, 32'h00000000, "underflow"};
        vecs[5] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow"};
        vecs[6] = '{32'hFF000000, 32'h7F000000, 32'hFF800000, "overflow_neg"};

        // Reset state
        rst = 1'b0;
        ce  = 1'b0;
        run = 1'b0;
        x   = 32'd0;
        y   = 32'd0;
        #12;
        chk("reset_stall_idle", {31'd0, stall}, 32'd0);
        chk("reset_s", {27'd0, dut.s_q}, 32'd0);
        chk("reset_p_lo", dut.p_q[31:0], 32'd0);
        run = 1'b1;
        ce  = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_stall_run", {31'd0, stall}, 32'd1);
        chk("reset_s_hold", {27'd0, dut.s_q}, 32'd0);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;

        // Table-driven vectors, ce held high
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, en_c, clk_c);
            chk({vecs[i].name, "_latency"}, en_c, 32'd25);
            chk({vecs[i].name, "_z"}, z, vecs[i].exp_z);
            chk({vecs[i].name, "_stall"}, {31'd0, stall}, 32'd0);
            end_op();
            chk({vecs[i].name, "_idle"}, {31'd0, stall}, 32'd0);
        end

        // ce toggled every other clock
        do_op(32'h3FC00000, 32'h3FC00000, 1'b1, en_c, clk_c);
        chk("ce_toggle_en_cycles", en_c, 32'd25);
        chk("ce_toggle_clk_cycles", clk_c, 32'd50);
        chk("ce_toggle_z", z, 32'h40100000);
        // Hold run 5 more enabled cycles: counter parks, result stable
        ce = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("hold_stall", {31'd0, stall}, 32'd0);
            chk("hold_z", z, 32'h40100000);
        end
        chk("hold_s", {27'd0, dut.s_q}, 32'd25);
        end_op();

        // Reset asserted mid-operation at S=12
        @(negedge clk);
        x   = 32'h40000000;
        y   = 32'hC0400000;
        run = 1'b1;
        ce  = 1'b1;
        for (int k = 0; k < 12; k++) @(negedge clk);
        #1;
        chk("mid_s_before", {27'd0, dut.s_q}, 32'd12);
        rst = 1'b0;
        #1;
        chk("mid_rst_s", {27'd0, dut.s_q}, 32'd0);
        chk("mid_rst_p_hi", {16'd0, dut.p_q[47:32]}, 32'd0);
        chk("mid_rst_p_lo", dut.p_q[31:0], 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_done(1'b0, en_c, clk_c);
        chk("post_rst_latency", en_c, 32'd25);
        chk("post_rst_z", z, 32'hC0C00000);
        z_hold = z;
        @(negedge clk);
        #1;
        chk("post_rst_z_stable", z, z_hold);
        end_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
